// File: rtl/interval_pkg.sv
// interval_pkg: shared types and constants for the interval sequencer
// and its timing helpers.
package interval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam int CNT_W = 8;
    localparam int TICK_DIV_DEFAULT = 10000;
    localparam logic [CNT_W-1:0] END_MARK = '0;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV divider that emits one-cycle ticks
// while run is high and sits at zero otherwise.
module tick_prescaler #(
    parameter int TICK_DIV = 10000
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/interval_sequencer.sv
// interval_sequencer: steps an external terminal-count counter through a
// programmed interval table. Wrap mode: INTERVAL_SEQUENCER_LOOP_EN.
module interval_sequencer
    import interval_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int NPHASE   = 4,
    parameter int PHW      = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic             wr_en,
    input  logic [PHW-1:0]   wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             cnt_rco,
    output logic             cnt_clr_n,
    output logic             cnt_en,
    output logic [CNT_W-1:0] cnt_limit,
    output logic [PHW-1:0]   phase,
    output logic             busy,
    output logic             phase_done,
    output logic             seq_done
);
    localparam logic [PHW-1:0] LAST_PH = PHW'(NPHASE - 1);

    state_t           state;
    state_t           state_n;
    logic [PHW-1:0]   phase_n;
    logic [PHW-1:0]   phase_inc;
    logic             pd_n;
    logic             sd_n;
    logic             seq_end;
    logic             running;
    logic [CNT_W-1:0] tbl [NPHASE];

    assign phase_inc = phase + 1'b1;
    // Look one entry ahead so a trailing zero ends the sequence
    // directly from the RCO cycle instead of via an extra LOAD.
    assign seq_end   = (phase == LAST_PH) || (tbl[phase_inc] == END_MARK);
    assign running   = (state == RUN);
    assign cnt_clr_n = running;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk (clk),
        .clr (clr),
        .run (running && !cnt_rco),
        .tick(cnt_en)
    );

    always_comb begin
        state_n = state;
        phase_n = phase;
        pd_n    = 1'b0;
        sd_n    = 1'b0;
        unique case (state)
            IDLE: begin
                phase_n = '0;
                if (start) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                    phase_n = '0;
                end else if (tbl[phase] == END_MARK) begin
                    state_n = DONE;
                    sd_n    = 1'b1;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    phase_n = '0;
                end else if (cnt_rco) begin
                    pd_n = 1'b1;
                    if (seq_end) begin
                        sd_n = 1'b1;
`ifdef INTERVAL_SEQUENCER_LOOP_EN
                        state_n = LOAD;
                        phase_n = '0;
`else
                        state_n = DONE;
`endif
                    end else begin
                        state_n = LOAD;
                        phase_n = phase_inc;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                phase_n = '0;
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            phase      <= '0;
            cnt_limit  <= '0;
            busy       <= 1'b0;
            phase_done <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            busy       <= (state_n == LOAD) || (state_n == RUN);
            phase_done <= pd_n;
            seq_done   <= sd_n;
            if (state_n == LOAD) begin
                cnt_limit <= tbl[phase_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NPHASE; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_en && (state == IDLE || state == DONE)) begin
            tbl[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_interval_sequencer.sv
// tb_interval_sequencer: randomized self-checking bench with an
// event-arithmetic reference model and a behavioural terminal counter.
module tb_interval_sequencer;
    localparam int T    = 4;
    localparam int MAXC = 200;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       cnt_rco;
    logic       cnt_clr_n;
    logic       cnt_en;
    logic [7:0] cnt_limit;
    logic [1:0] phase;
    logic       busy;
    logic       phase_done;
    logic       seq_done;
    logic [7:0] cnt_q = '0;

    int n_chk = 0;
    int n_fail = 0;
    int m_tbl [4];

    bit e_en   [MAXC];
    bit e_pd   [MAXC];
    bit e_sd   [MAXC];
    bit e_busy [MAXC];
    bit e_clrn [MAXC];
    int e_ph   [MAXC];
    int e_lim  [MAXC];

    always #5 clk = ~clk;

    interval_sequencer #(
        .TICK_DIV(T),
        .NPHASE  (4),
        .PHW     (2)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .abort     (abort),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cnt_rco   (cnt_rco),
        .cnt_clr_n (cnt_clr_n),
        .cnt_en    (cnt_en),
        .cnt_limit (cnt_limit),
        .phase     (phase),
        .busy      (busy),
        .phase_done(phase_done),
        .seq_done  (seq_done)
    );

    // Terminal-count counter: clear, enable, RCO when Q equals the limit.
    always_ff @(posedge clk) begin
        if (!cnt_clr_n) cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 8'd1;
    end
    assign cnt_rco = (cnt_q == cnt_limit);

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic write_tbl(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 2'(a);
        wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
        m_tbl[a] = d;
    endtask

    // Cycle 0 is the cycle where start is high; LOAD follows in cycle 1.
    task automatic build_model(input int span);
        int c, p, r, L;
        bit fin;
        for (int i = 0; i < MAXC; i++) begin
            e_en[i] = 0; e_pd[i] = 0; e_sd[i] = 0;
            e_busy[i] = 0; e_clrn[i] = 0; e_ph[i] = 0; e_lim[i] = -1;
        end
        if (m_tbl[0] == 0) begin
            e_busy[1] = 1;
            e_sd[2] = 1;
            for (int i = 1; i < MAXC; i++) e_lim[i] = 0;
            return;
        end
        c = 1;
        p = 0;
        while (c < span) begin
            L = m_tbl[p];
            for (int i = c; i < MAXC; i++) e_lim[i] = L;
            r = c + 1;
            for (int i = c; i <= r + L * T && i < MAXC; i++) begin
                e_busy[i] = 1;
                e_ph[i] = p;
            end
            for (int i = r; i <= r + L * T && i < MAXC; i++) e_clrn[i] = 1;
            for (int k = 1; k <= L; k++)
                if (r + k * T - 1 < MAXC) e_en[r + k * T - 1] = 1;
            c = r + L * T + 1;
            if (c >= MAXC) break;
            e_pd[c] = 1;
            fin = (p == 3);
            if (!fin) fin = (m_tbl[p + 1] == 0);
            if (fin) begin
                e_sd[c] = 1;
`ifdef INTERVAL_SEQUENCER_LOOP_EN
                p = 0;
`else
                e_ph[c] = p;
                break;
`endif
            end else begin
                p++;
            end
        end
    endtask

    task automatic run_seq(input string name, input int span, input bit strobes);
        build_model(span);
        for (int i = 0; i < span; i++) begin
            if (i > 0) @(negedge clk);
            start = (i == 0);
            wr_en = 1'b0;
            n_chk += 6;
            if (cnt_en !== e_en[i]) begin
                n_fail++;
                $display("FAIL %s cyc %0d cnt_en got %0b exp %0b", name, i, cnt_en, e_en[i]);
            end
            if (phase_done !== e_pd[i]) begin
                n_fail++;
                $display("FAIL %s cyc %0d phase_done got %0b exp %0b", name, i, phase_done, e_pd[i]);
            end
            if (seq_done !== e_sd[i]) begin
                n_fail++;
                $display("FAIL %s cyc %0d seq_done got %0b exp %0b", name, i, seq_done, e_sd[i]);
            end
            if (busy !== e_busy[i]) begin
                n_fail++;
                $display("FAIL %s cyc %0d busy got %0b exp %0b", name, i, busy, e_busy[i]);
            end
            if (cnt_clr_n !== e_clrn[i]) begin
                n_fail++;
                $display("FAIL %s cyc %0d cnt_clr_n got %0b exp %0b", name, i, cnt_clr_n, e_clrn[i]);
            end
            if (phase !== 2'(e_ph[i])) begin
                n_fail++;
                $display("FAIL %s cyc %0d phase got %0d exp %0d", name, i, phase, e_ph[i]);
            end
            if (e_lim[i] >= 0) begin
                n_chk++;
                if (cnt_limit !== 8'(e_lim[i])) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d cnt_limit got %0d exp %0d", name, i, cnt_limit, e_lim[i]);
                end
            end
            if (strobes && i >= 1 && e_busy[i] && $urandom_range(0, 2) == 0) begin
                start   = 1'($urandom_range(0, 1));
                wr_en   = 1'b1;
                wr_addr = 2'($urandom_range(0, 3));
                wr_data = 8'($urandom_range(1, 255));
            end
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s settle busy got %0b exp 0", name, busy);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        write_tbl(0, 5); write_tbl(1, 6); write_tbl(2, 7); write_tbl(3, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset pre busy got %0b exp 1", busy);
        end
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) m_tbl[i] = 0;
        n_chk += 7;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %0b exp 0", busy); end
        if (phase !== 2'd0) begin n_fail++; $display("FAIL reset phase got %0d exp 0", phase); end
        if (cnt_limit !== 8'd0) begin n_fail++; $display("FAIL reset cnt_limit got %0d exp 0", cnt_limit); end
        if (cnt_clr_n !== 1'b0) begin n_fail++; $display("FAIL reset cnt_clr_n got %0b exp 0", cnt_clr_n); end
        if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset cnt_en got %0b exp 0", cnt_en); end
        if (phase_done !== 1'b0) begin n_fail++; $display("FAIL reset phase_done got %0b exp 0", phase_done); end
        if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset seq_done got %0b exp 0", seq_done); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (dut.tbl[i] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset tbl[%0d] got %0d exp 0", i, dut.tbl[i]);
            end
        end
    endtask

    task automatic test_two_phases();
        write_tbl(0, 3); write_tbl(1, 2); write_tbl(2, 0); write_tbl(3, 0);
`ifdef INTERVAL_SEQUENCER_LOOP_EN
        run_seq("two_phases", 80, 1'b0);
`else
        run_seq("two_phases", 32, 1'b0);
`endif
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 4; i++) write_tbl(i, 1);
`ifdef INTERVAL_SEQUENCER_LOOP_EN
        run_seq("full_table", 80, 1'b0);
`else
        run_seq("full_table", 32, 1'b0);
`endif
    endtask

    task automatic test_abort();
        int cyc;
        bit hit;
        for (int i = 0; i < 4; i++) write_tbl(i, 2);
        start = 1'b1;
        cyc = 0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) start = 1'b0;
            if (cnt_rco === 1'b1 && busy === 1'b1 && phase === 2'd0) begin
                hit = 1;
                cyc = i;
            end
        end
        start = 1'b0;
        n_chk++;
        if (!hit || cyc != 2 + 2 * T) begin
            n_fail++;
            $display("FAIL abort rco_cycle got %0d exp %0d", hit ? cyc : -1, 2 + 2 * T);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy got %0b exp 0", busy); end
        if (cnt_clr_n !== 1'b0) begin n_fail++; $display("FAIL abort cnt_clr_n got %0b exp 0", cnt_clr_n); end
        if (phase_done !== 1'b0) begin n_fail++; $display("FAIL abort phase_done got %0b exp 0", phase_done); end
        if (seq_done !== 1'b0) begin n_fail++; $display("FAIL abort seq_done got %0b exp 0", seq_done); end
        if (phase !== 2'd0) begin n_fail++; $display("FAIL abort phase got %0d exp 0", phase); end
        @(negedge clk);
    endtask

    task automatic test_illegal_strobes();
        write_tbl(0, 2); write_tbl(1, 3); write_tbl(2, 1); write_tbl(3, 2);
        run_seq("illegal_strobes", 60, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (dut.tbl[i] !== 8'(m_tbl[i])) begin
                n_fail++;
                $display("FAIL strobes tbl[%0d] got %0d exp %0d", i, dut.tbl[i], m_tbl[i]);
            end
        end
    endtask

    task automatic test_zero_first();
        write_tbl(0, 0); write_tbl(1, 3); write_tbl(2, 3); write_tbl(3, 3);
        run_seq("zero_first", 8, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++)
                write_tbl(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4));
            run_seq("random", 90, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_tbl[i] = 0;
        test_reset();
        test_two_phases();
        test_full_table();
        test_abort();
        test_illegal_strobes();
        test_zero_first();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
